// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register-mapped per-pad controls, synchronized input sampling,
// and sticky write-1-to-clear edge capture.
module gpio_pad_ctrl #(
    parameter int NUM_BIDIR = 42
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [3:0]           wr_addr,
    input  logic [NUM_BIDIR-1:0] wr_data,
    input  logic [3:0]           rd_addr,
    output logic [NUM_BIDIR-1:0] rd_data,
    input  logic [NUM_BIDIR-1:0] bidir_in,
    output logic [NUM_BIDIR-1:0] bidir_out,
    output logic [NUM_BIDIR-1:0] bidir_oe,
    output logic [NUM_BIDIR-1:0] bidir_cs,
    output logic [NUM_BIDIR-1:0] bidir_sl,
    output logic [NUM_BIDIR-1:0] bidir_ie,
    output logic [NUM_BIDIR-1:0] bidir_pu,
    output logic [NUM_BIDIR-1:0] bidir_pd
);

    localparam int A_OUT  = 0;
    localparam int A_OE   = 1;
    localparam int A_IE   = 2;
    localparam int A_PU   = 3;
    localparam int A_PD   = 4;
    localparam int A_CS   = 5;
    localparam int A_SL   = 6;
    localparam int NUM_CFG = 7;

    logic [NUM_BIDIR-1:0] r_cfg [0:NUM_CFG-1];
    logic [NUM_BIDIR-1:0] r_edge;
    logic [NUM_BIDIR-1:0] r_s1;
    logic [NUM_BIDIR-1:0] r_s2;
    logic [NUM_BIDIR-1:0] r_s3;
    logic [NUM_BIDIR-1:0] r_rd_data;
    logic [1:0]           r_arm;
    logic                 r_ready;

    logic                 w_wr_en;
    logic                 w_armed;
    logic [NUM_CFG-1:0]   w_cfg_we;
    logic [NUM_BIDIR-1:0] w_in;
    logic [NUM_BIDIR-1:0] w_edge_det;
    logic [NUM_BIDIR-1:0] w_edge_clr;
    logic [NUM_BIDIR-1:0] w_edge_next;
    logic [NUM_BIDIR-1:0] w_rd_next;

    assign wr_ready = r_ready & ~rst;
    assign w_wr_en  = wr_valid & wr_ready;
    assign w_armed  = (r_arm == 2'd3);
    assign w_in     = r_s2 & r_cfg[A_IE];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg_we
            assign w_cfg_we[gi] = w_wr_en && (wr_addr == 4'(gi));
        end
        // A fresh edge outranks a simultaneous clear so no event is ever lost.
        for (gi = 0; gi < NUM_BIDIR; gi++) begin : g_pad
            assign w_edge_det[gi]  = w_armed && r_cfg[A_IE][gi] && (r_s2[gi] != r_s3[gi]);
            assign w_edge_clr[gi]  = w_wr_en && (wr_addr == 4'd8) && wr_data[gi];
            assign w_edge_next[gi] = w_edge_det[gi] | (r_edge[gi] & ~w_edge_clr[gi]);
            assign bidir_pd[gi]    = r_cfg[A_PD][gi] & ~r_cfg[A_PU][gi];
        end
    endgenerate

    always_comb begin
        w_rd_next = '0;
        case (rd_addr)
            4'd0:    w_rd_next = r_cfg[A_OUT];
            4'd1:    w_rd_next = r_cfg[A_OE];
            4'd2:    w_rd_next = r_cfg[A_IE];
            4'd3:    w_rd_next = r_cfg[A_PU];
            4'd4:    w_rd_next = r_cfg[A_PD];
            4'd5:    w_rd_next = r_cfg[A_CS];
            4'd6:    w_rd_next = r_cfg[A_SL];
            4'd7:    w_rd_next = w_in;
            4'd8:    w_rd_next = r_edge;
            default: w_rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                r_cfg[i] <= (i == A_IE) ? '1 : '0;
            end
            r_edge    <= '0;
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_rd_data <= '0;
            r_arm     <= 2'd0;
            r_ready   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (w_cfg_we[i]) begin
                    r_cfg[i] <= wr_data;
                end
            end
            r_edge    <= w_edge_next;
            r_s1      <= bidir_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_rd_data <= w_rd_next;
            r_ready   <= 1'b1;
            if (!w_armed) begin
                r_arm <= r_arm + 2'd1;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign bidir_out = r_cfg[A_OUT];
    assign bidir_oe  = r_cfg[A_OE];
    assign bidir_ie  = r_cfg[A_IE];
    assign bidir_cs  = r_cfg[A_CS];
    assign bidir_sl  = r_cfg[A_SL];
    assign bidir_pu  = r_cfg[A_PU];

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: read expectations are queued when a read
// is issued and popped when the registered rd_data appears.
module tb_gpio_pad_ctrl;

    localparam int N = 42;
    localparam logic [N-1:0] ALL1 = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic [3:0]   rd_addr;
    logic [N-1:0] rd_data;
    logic [N-1:0] bidir_in;
    logic [N-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_v;

    gpio_pad_ctrl #(.NUM_BIDIR(N)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .bidir_in(bidir_in),
        .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
        .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [3:0] a, input logic [N-1:0] e);
        rd_addr = a;
        exp_q.push_back(e);
        tick();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [N-1:0] d);
        int k;
        k = 0;
        while (!wr_ready && k < 10) begin
            tick();
            k++;
        end
        if (!wr_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_ready_timeout: got %0b want 1", wr_ready);
        end
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b1; wr_addr = 4'd0; wr_data = ALL1;
        tick();
        n_cmp++;
        if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_in_reset: got %0b want 0", wr_ready); end
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        n_cmp++;
        if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_after_release: got %0b want 0", wr_ready); end
        tick();
        n_cmp++;
        if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_up: got %0b want 1", wr_ready); end
        n_cmp++;
        if (bidir_out !== '0 || bidir_oe !== '0 || bidir_cs !== '0 || bidir_sl !== '0 ||
            bidir_pu !== '0 || bidir_pd !== '0) begin
            n_err++;
            $display("FAIL rst_outputs: out=%h oe=%h cs=%h sl=%h pu=%h pd=%h want all 0",
                     bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_pu, bidir_pd);
        end
        n_cmp++;
        if (bidir_ie !== ALL1) begin n_err++; $display("FAIL rst_ie: got %h want %h", bidir_ie, ALL1); end
        n_cmp++;
        if (rd_data !== '0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    endtask

    task automatic test_write_read();
        do_write(4'd1, 42'h3FF_FFFF_FFFF);
        issue_read(4'd1, 42'h3FF_FFFF_FFFF);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL rd_oe: got %h want %h", rd_data, exp_v); end
        n_cmp++;
        if (bidir_oe !== 42'h3FF_FFFF_FFFF) begin n_err++; $display("FAIL bidir_oe: got %h want %h", bidir_oe, 42'h3FF_FFFF_FFFF); end
        do_write(4'd12, ALL1);
        issue_read(4'd12, '0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL rd_unmapped: got %h want %h", rd_data, exp_v); end
        do_write(4'd7, ALL1);
        issue_read(4'd7, '0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL rd_in_readonly: got %h want %h", rd_data, exp_v); end
    endtask

    task automatic test_read_during_write();
        rd_addr = 4'd0;
        exp_q.push_back('0);
        wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 42'h2AB_CDEF_0123;
        tick();
        wr_valid = 1'b0;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL rdw_old_value: got %h want %h", rd_data, exp_v); end
        n_cmp++;
        if (bidir_out !== 42'h2AB_CDEF_0123) begin n_err++; $display("FAIL rdw_out: got %h want %h", bidir_out, 42'h2AB_CDEF_0123); end
        issue_read(4'd0, 42'h2AB_CDEF_0123);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL rdw_new_value: got %h want %h", rd_data, exp_v); end
    endtask

    task automatic test_pull();
        do_write(4'd3, 42'h5);
        do_write(4'd4, 42'h6);
        n_cmp++;
        if (bidir_pu !== 42'h5) begin n_err++; $display("FAIL pull_pu: got %h want 5", bidir_pu); end
        n_cmp++;
        if (bidir_pd !== 42'h2) begin n_err++; $display("FAIL pull_pd: got %h want 2", bidir_pd); end
        issue_read(4'd4, 42'h6);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL pull_rd_pd: got %h want %h", rd_data, exp_v); end
    endtask

    task automatic test_back_to_back();
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 42'h155_5555_5555;
        tick();
        wr_addr = 4'd6; wr_data = 42'h0AA_AAAA_AAAA;
        tick();
        wr_valid = 1'b0;
        n_cmp++;
        if (bidir_cs !== 42'h155_5555_5555) begin n_err++; $display("FAIL b2b_cs: got %h want %h", bidir_cs, 42'h155_5555_5555); end
        n_cmp++;
        if (bidir_sl !== 42'h0AA_AAAA_AAAA) begin n_err++; $display("FAIL b2b_sl: got %h want %h", bidir_sl, 42'h0AA_AAAA_AAAA); end
    endtask

    task automatic test_edge();
        bidir_in[3] = 1'b1;
        tick(); tick(); tick();
        issue_read(4'd8, 42'h8);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL edge_set: got %h want %h", rd_data, exp_v); end
        issue_read(4'd7, 42'h8);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL edge_in: got %h want %h", rd_data, exp_v); end
        do_write(4'd8, 42'h8);
        issue_read(4'd8, '0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL edge_w1c: got %h want %h", rd_data, exp_v); end
    endtask

    task automatic test_collision();
        bidir_in[3] = 1'b0;
        tick(); tick();
        do_write(4'd8, 42'h8);
        issue_read(4'd8, 42'h8);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL collision_keep: got %h want %h", rd_data, exp_v); end
        do_write(4'd8, 42'h8);
        issue_read(4'd8, '0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL collision_clear: got %h want %h", rd_data, exp_v); end
    endtask

    task automatic test_ie_mask();
        do_write(4'd2, ALL1 & ~42'h1);
        n_cmp++;
        if (bidir_ie !== (ALL1 & ~42'h1)) begin n_err++; $display("FAIL ie_out: got %h want %h", bidir_ie, ALL1 & ~42'h1); end
        bidir_in[0] = 1'b1;
        tick(); tick(); tick(); tick();
        issue_read(4'd7, '0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL ie_in_masked: got %h want %h", rd_data, exp_v); end
        issue_read(4'd8, '0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL ie_edge_masked: got %h want %h", rd_data, exp_v); end
    endtask

    task automatic test_arming();
        bidir_in = ALL1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        issue_read(4'd8, '0);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL arm_no_edge: got %h want %h", rd_data, exp_v); end
        issue_read(4'd7, ALL1);
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== exp_v) begin n_err++; $display("FAIL arm_in: got %h want %h", rd_data, exp_v); end
        n_cmp++;
        if (bidir_out !== '0 || bidir_cs !== '0) begin
            n_err++;
            $display("FAIL arm_reset_cfg: out=%h cs=%h want 0", bidir_out, bidir_cs);
        end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; bidir_in = '0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_pull();
        test_back_to_back();
        test_edge();
        test_collision();
        test_ie_mask();
        test_arming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_pad_ctrl.md
GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

Interface
REQ-001 SHALL have parameter NUM_BIDIR, default 42: number of bidirectional pads controlled.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-004 SHALL have port wr_valid  in  1: register write request.
REQ-005 SHALL have port wr_ready  out  1: write accepted when wr_valid&&wr_ready at a clk edge.
REQ-006 SHALL have port wr_addr  in  4: write register address.
REQ-007 SHALL have port wr_data  in  NUM_BIDIR: write data.
REQ-008 SHALL have port rd_addr  in  4: read register address.
REQ-009 SHALL have port rd_data  out  NUM_BIDIR: registered read data.
REQ-010 SHALL have port bidir_in  in  NUM_BIDIR: raw pad input values (asynchronous to clk).
REQ-011 SHALL have ports bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd  out  NUM_BIDIR each: per-pad control, one bit per pad.

Function
REQ-012 SHALL hold the register map 0=OUT, 1=OE, 2=IE, 3=PU, 4=PD, 5=CS, 6=SL, 7=IN (read-only), 8=EDGE (write-1-to-clear); addresses 9-15 SHALL read 0 and ignore writes.
REQ-013 SHALL update registers 0-6 with wr_data on the edge where the write is accepted; writes to 7 SHALL be ignored.
REQ-014 SHALL drive bidir_out, bidir_oe, bidir_ie, bidir_cs and bidir_sl directly from registers OUT, OE, IE, CS and SL.
REQ-015 SHALL drive bidir_pu = PU and bidir_pd = PD & ~PU, so PU wins and both pulls are never asserted on one pad.
REQ-016 SHALL drive wr_ready low while rst is high and during the cycle after rst deasserts, then high constantly.
REQ-017 SHALL pass bidir_in through a two-flop synchronizer (s1, s2) plus a history flop s3, each reset to 0.
REQ-018 SHALL read IN as s2 & IE.
REQ-019 SHALL set EDGE[i] when s2[i]!=s3[i] and IE[i]=1 (either edge direction); EDGE bits SHALL be sticky.
REQ-020 SHALL clear EDGE[i] on an accepted write to address 8 with wr_data[i]=1; a simultaneous new edge on pad i SHALL take priority and leave EDGE[i]=1.
REQ-021 SHALL suppress edge detection for 3 cycles after rst deasserts, using an arm counter (0..3, saturating), so reset-time flop initialisation never produces an edge.
REQ-022 SHALL register rd_data each cycle from rd_addr, giving 1-cycle read latency.
REQ-023 SHALL return the pre-write value when a read and a write target the same address in the same cycle.
REQ-024 SHALL clamp wr_data and rd_data to NUM_BIDIR bits; there are no partial-width or byte writes.

Reset
REQ-025 SHALL reset, while rst=1 at a clk edge, OUT=0, OE=0, IE=all 1s, PU=0, PD=0, CS=0, SL=0, EDGE=0, rd_data=0, s1/s2/s3=0 and arm counter=0.
REQ-026 SHALL abandon any write presented in a cycle where rst=1; a reset asserted mid-operation SHALL discard all state on the next edge.

Verification
REQ-027 SHALL be verified by this reset check: hold rst 2 cycles, release -> wr_ready=0 for 1 cycle then 1; all outputs at reset values; bidir_ie all 1s.
REQ-028 SHALL be verified by this write/read check: write OE=0x3FF_FFFF_FFFF then read addr 1 -> rd_data equals it 1 cycle later and bidir_oe matches; read addr 12 -> 0.
REQ-029 SHALL be verified by this pull check: write PU=0x5, then PD=0x6 -> bidir_pu=0x5, bidir_pd=0x2.
REQ-030 SHALL be verified by this edge check: toggle bidir_in[3] 0->1 after arming -> IN[3]=1 and EDGE=0x8 within 3 cycles; W1C 0x8 -> EDGE=0.
REQ-031 SHALL be verified by this collision check: W1C EDGE[3] in the same cycle a new edge on pad 3 reaches s2/s3 -> EDGE[3] stays 1.
REQ-032 SHALL be verified by this arming/IE check: hold bidir_in=all 1s through reset -> EDGE stays 0; set IE[0]=0 and toggle pad 0 -> IN[0]=0 and EDGE[0]=0.
